// File: rtl/result_write_arbiter.sv
// result_write_arbiter: per-lane result FIFOs drained round-robin onto one frame-buffer write port.
// Define RESULT_ARB_DROP_COUNT_EN to implement the saturating dropped-write counter on oDropCount.
`timescale 1ns/1ps
module result_write_arbiter #(
    parameter int NUM_LANES       = 7,
    parameter int LANE_BITS       = 3,
    parameter int WIDTH_BITS      = 8,
    parameter int HEIGHT_BITS     = 8,
    parameter int FIFO_DEPTH_BITS = 2
) (
    input  logic                              clock,
    input  logic                              not_reset,
    input  logic [NUM_LANES-1:0]              iWren,
    input  logic [NUM_LANES*WIDTH_BITS-1:0]   iCol,
    input  logic [NUM_LANES*HEIGHT_BITS-1:0]  iRow,
    input  logic [NUM_LANES-1:0]              iData,
    output logic [NUM_LANES-1:0]              oStall,
    output logic [HEIGHT_BITS-1:0]            oX,
    output logic [WIDTH_BITS-1:0]             oY,
    output logic [2:0]                        oR,
    output logic [2:0]                        oG,
    output logic [2:0]                        oB,
    output logic                              oWren,
    output logic                              oBusy,
    output logic                              oOverflow,
    output logic [15:0]                       oDropCount
);
    localparam int DEPTH      = 1 << FIFO_DEPTH_BITS;
    localparam int ENTRY_BITS = HEIGHT_BITS + WIDTH_BITS + 1;
    localparam logic [FIFO_DEPTH_BITS:0] FULL = (FIFO_DEPTH_BITS+1)'(DEPTH);

    typedef logic [ENTRY_BITS-1:0] entry_t;

    entry_t                     mem_q    [NUM_LANES][DEPTH];
    entry_t                     mem_d    [NUM_LANES][DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q [NUM_LANES];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr_d [NUM_LANES];
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr_q [NUM_LANES];
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr_d [NUM_LANES];
    logic [FIFO_DEPTH_BITS:0]   count_q  [NUM_LANES];
    logic [FIFO_DEPTH_BITS:0]   count_d  [NUM_LANES];
    logic [LANE_BITS-1:0]       last_grant_q, last_grant_d;
    logic [LANE_BITS-1:0]       grant_lane, sel_hi, sel_lo;
    logic                       found_hi, found_lo, grant_valid;
    logic [NUM_LANES-1:0]       push, pop, drop, nonempty;
    entry_t                     head;
    logic                       wren_q, wren_d;
    logic [HEIGHT_BITS-1:0]     x_q, x_d;
    logic [WIDTH_BITS-1:0]      y_q, y_d;
    logic                       pix_q, pix_d;
    logic                       overflow_q, overflow_d;

    // Stall looks only at the registered count, so a full lane drops even if popped this cycle.
    always_comb begin
        oStall   = '0;
        push     = '0;
        drop     = '0;
        nonempty = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            oStall[i]   = count_q[i] == FULL;
            push[i]     = iWren[i] & ~oStall[i];
            drop[i]     = iWren[i] & oStall[i];
            nonempty[i] = count_q[i] != '0;
        end
    end

    // Lowest non-empty lane above last_grant wins; otherwise wrap to the lowest at or below it.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        sel_hi   = '0;
        sel_lo   = '0;
        for (int j = NUM_LANES - 1; j >= 0; j--) begin
            if (nonempty[j] && LANE_BITS'(j) > last_grant_q) begin
                found_hi = 1'b1;
                sel_hi   = LANE_BITS'(j);
            end
            if (nonempty[j] && LANE_BITS'(j) <= last_grant_q) begin
                found_lo = 1'b1;
                sel_lo   = LANE_BITS'(j);
            end
        end
        grant_valid = found_hi | found_lo;
        grant_lane  = found_hi ? sel_hi : sel_lo;
        pop  = '0;
        head = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (grant_valid && LANE_BITS'(i) == grant_lane) begin
                pop[i] = 1'b1;
                head   = mem_q[i][rd_ptr_q[i]];
            end
        end
    end

    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + FIFO_DEPTH_BITS'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + FIFO_DEPTH_BITS'(pop[i]);
            count_d[i]  = count_q[i] + (FIFO_DEPTH_BITS+1)'(push[i]) - (FIFO_DEPTH_BITS+1)'(pop[i]);
            if (push[i])
                mem_d[i][wr_ptr_q[i]] = {iRow[i*HEIGHT_BITS +: HEIGHT_BITS],
                                         iCol[i*WIDTH_BITS +: WIDTH_BITS], iData[i]};
        end
        wren_d       = grant_valid;
        x_d          = grant_valid ? head[ENTRY_BITS-1 -: HEIGHT_BITS] : x_q;
        y_d          = grant_valid ? head[WIDTH_BITS:1] : y_q;
        pix_d        = grant_valid ? head[0] : pix_q;
        last_grant_d = grant_valid ? grant_lane : last_grant_q;
        overflow_d   = overflow_q | (|drop);
    end

    always_ff @(posedge clock) mem_q <= mem_d;

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            last_grant_q <= LANE_BITS'(NUM_LANES - 1);
            wren_q       <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            pix_q        <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            wren_q       <= wren_d;
            x_q          <= x_d;
            y_q          <= y_d;
            pix_q        <= pix_d;
            overflow_q   <= overflow_d;
        end
    end

`ifdef RESULT_ARB_DROP_COUNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [16:0] drop_sum;

    always_comb begin
        drop_sum = {1'b0, drop_cnt_q};
        for (int i = 0; i < NUM_LANES; i++)
            drop_sum = drop_sum + 17'(drop[i]);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset)
            drop_cnt_q <= '0;
        else
            drop_cnt_q <= drop_cnt_d;
    end

    assign oDropCount = drop_cnt_q;
`else
    assign oDropCount = 16'h0000;
`endif

    assign oWren     = wren_q;
    assign oX        = x_q;
    assign oY        = y_q;
    assign oR        = {3{pix_q}};
    assign oG        = {3{pix_q}};
    assign oB        = {3{pix_q}};
    assign oOverflow = overflow_q;
    assign oBusy     = (|nonempty) | wren_q;
endmodule

// File: tb/tb_result_write_arbiter.sv
// tb_result_write_arbiter: directed self-checking bench for result_write_arbiter.
`timescale 1ns/1ps
module tb_result_write_arbiter;
    logic        clock = 1'b0;
    logic        not_reset = 1'b1;
    logic [6:0]  iWren = '0;
    logic [55:0] iCol = '0;
    logic [55:0] iRow = '0;
    logic [6:0]  iData = '0;
    logic [6:0]  oStall;
    logic [7:0]  oX, oY;
    logic [2:0]  oR, oG, oB;
    logic        oWren, oBusy, oOverflow;
    logic [15:0] oDropCount;
    int passed = 0;
    int total = 0;

    result_write_arbiter dut (
        .clock(clock), .not_reset(not_reset), .iWren(iWren), .iCol(iCol), .iRow(iRow),
        .iData(iData), .oStall(oStall), .oX(oX), .oY(oY), .oR(oR), .oG(oG), .oB(oB),
        .oWren(oWren), .oBusy(oBusy), .oOverflow(oOverflow), .oDropCount(oDropCount)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [7:0] row, input logic [7:0] col, input logic d);
        iRow[i*8 +: 8] = row;
        iCol[i*8 +: 8] = col;
        iData[i] = d;
    endtask

    task automatic do_reset;
        iWren = '0;
        not_reset = 1'b0;
        tick;
        tick;
        not_reset = 1'b1;
    endtask

    task automatic load_burst;
        for (int i = 0; i < 7; i++) set_lane(i, 8'(i), 8'(8'hA0 + i), i[0]);
    endtask

    task automatic test_reset;
        #2 not_reset = 1'b0;
        #1;
        total++; if (oWren !== 1'b0) $display("FAIL reset_wren: got %b want 0", oWren); else passed++;
        total++; if (oX !== 8'h00 || oY !== 8'h00) $display("FAIL reset_xy: got %h/%h want 00/00", oX, oY); else passed++;
        total++; if ({oR, oG, oB} !== 9'h0) $display("FAIL reset_rgb: got %h want 000", {oR, oG, oB}); else passed++;
        total++; if (oBusy !== 1'b0) $display("FAIL reset_busy: got %b want 0", oBusy); else passed++;
        total++; if (oOverflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", oOverflow); else passed++;
        total++; if (oDropCount !== 16'h0) $display("FAIL reset_dropcount: got %h want 0000", oDropCount); else passed++;
        total++; if (oStall !== 7'h0) $display("FAIL reset_stall: got %b want 0000000", oStall); else passed++;
        tick;
        tick;
        not_reset = 1'b1;
    endtask

    task automatic test_single;
        set_lane(3, 8'h12, 8'h34, 1'b1);
        iWren = 7'b0001000;
        tick;
        iWren = '0;
        total++; if (oWren !== 1'b0) $display("FAIL single_early: got wren %b want 0", oWren); else passed++;
        total++; if (oBusy !== 1'b1) $display("FAIL single_busy: got %b want 1", oBusy); else passed++;
        tick;
        total++; if (oWren !== 1'b1) $display("FAIL single_wren: got %b want 1", oWren); else passed++;
        total++; if (oX !== 8'h12 || oY !== 8'h34) $display("FAIL single_xy: got %h/%h want 12/34", oX, oY); else passed++;
        total++; if ({oR, oG, oB} !== 9'h1FF) $display("FAIL single_rgb: got %h want 1ff", {oR, oG, oB}); else passed++;
        tick;
        total++; if (oWren !== 1'b0 || oBusy !== 1'b0) $display("FAIL single_idle: got wren %b busy %b want 0 0", oWren, oBusy); else passed++;
        total++; if (oX !== 8'h12) $display("FAIL single_hold: got %h want 12", oX); else passed++;
    endtask

    task automatic test_burst;
        do_reset;
        load_burst;
        iWren = '1;
        tick;
        iWren = '0;
        for (int k = 0; k < 7; k++) begin
            tick;
            total++;
            if (oWren !== 1'b1 || oX !== 8'(k) || oY !== 8'(8'hA0 + k) || oR !== {3{k[0]}})
                $display("FAIL burst_%0d: got wren %b x %h y %h r %b want 1 %h %h %b",
                         k, oWren, oX, oY, oR, 8'(k), 8'(8'hA0 + k), {3{k[0]}});
            else passed++;
        end
        tick;
        total++; if (oWren !== 1'b0) $display("FAIL burst_end: got wren %b want 0", oWren); else passed++;
        total++; if (oOverflow !== 1'b0) $display("FAIL burst_overflow: got %b want 0", oOverflow); else passed++;
    endtask

    task automatic test_reset_mid;
        do_reset;
        load_burst;
        iWren = '1;
        tick;
        iWren = '0;
        for (int k = 0; k < 3; k++) begin
            tick;
            total++; if (oX !== 8'(k)) $display("FAIL midrst_pre_%0d: got x %h want %h", k, oX, 8'(k)); else passed++;
        end
        not_reset = 1'b0;
        #1;
        total++; if (oWren !== 1'b0) $display("FAIL midrst_wren: got %b want 0", oWren); else passed++;
        total++; if (oBusy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", oBusy); else passed++;
        total++; if (oOverflow !== 1'b0) $display("FAIL midrst_overflow: got %b want 0", oOverflow); else passed++;
        tick;
        tick;
        not_reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            total++; if (oWren !== 1'b0) $display("FAIL midrst_stale_%0d: got wren %b want 0", k, oWren); else passed++;
        end
        set_lane(0, 8'h55, 8'h66, 1'b0);
        iWren = 7'b0000001;
        tick;
        iWren = '0;
        total++; if (oWren !== 1'b0) $display("FAIL midrst_new_early: got wren %b want 0", oWren); else passed++;
        tick;
        total++;
        if (oWren !== 1'b1 || oX !== 8'h55 || oY !== 8'h66 || oR !== 3'b000)
            $display("FAIL midrst_new: got wren %b x %h y %h r %b want 1 55 66 000", oWren, oX, oY, oR);
        else passed++;
    endtask

    task automatic test_wrap;
        do_reset;
        set_lane(6, 8'h60, 8'h06, 1'b1);
        iWren = 7'b1000000;
        tick;
        set_lane(6, 8'h61, 8'h06, 1'b0);
        set_lane(0, 8'h01, 8'h00, 1'b1);
        iWren = 7'b1000001;
        tick;
        iWren = '0;
        total++; if (oWren !== 1'b1 || oX !== 8'h60) $display("FAIL wrap_first: got wren %b x %h want 1 60", oWren, oX); else passed++;
        tick;
        total++; if (oWren !== 1'b1 || oX !== 8'h01) $display("FAIL wrap_lane0: got wren %b x %h want 1 01", oWren, oX); else passed++;
        tick;
        total++; if (oWren !== 1'b1 || oX !== 8'h61) $display("FAIL wrap_lane6: got wren %b x %h want 1 61", oWren, oX); else passed++;
        tick;
        total++; if (oWren !== 1'b0) $display("FAIL wrap_end: got wren %b want 0", oWren); else passed++;
    endtask

    task automatic test_fairness;
        int n;
        logic [7:0] exp_x;
        do_reset;
        set_lane(0, 8'h00, 8'h10, 1'b1);
        set_lane(5, 8'h05, 8'h15, 1'b0);
        for (int c = 0; c < 20; c++) begin
            iWren = '0;
            iWren[0] = ~oStall[0];
            iWren[5] = ~oStall[5];
            tick;
            if (c > 0) begin
                exp_x = ((c - 1) % 2 == 1) ? 8'h05 : 8'h00;
                total++;
                if (oWren !== 1'b1 || oX !== exp_x)
                    $display("FAIL fair_%0d: got wren %b x %h want 1 %h", c, oWren, oX, exp_x);
                else passed++;
            end
        end
        iWren = '0;
        n = 0;
        while (oBusy === 1'b1 && n < 50) begin
            tick;
            n++;
        end
        total++; if (oBusy !== 1'b0) $display("FAIL fair_drain: got busy %b want 0", oBusy); else passed++;
        total++; if (oOverflow !== 1'b0) $display("FAIL fair_overflow: got %b want 0", oOverflow); else passed++;
    endtask

    task automatic test_overflow;
        int writes;
        int n;
        logic [15:0] exp_drop;
`ifdef RESULT_ARB_DROP_COUNT_EN
        exp_drop = 16'd34;
`else
        exp_drop = 16'd0;
`endif
        do_reset;
        load_burst;
        writes = 0;
        for (int c = 0; c < 10; c++) begin
            iWren = '1;
            tick;
            if (oWren === 1'b1) writes++;
            if (c == 0) begin
                total++; if (oStall !== 7'b0000000) $display("FAIL ovf_stall0: got %b want 0000000", oStall); else passed++;
            end
            if (c == 3) begin
                total++; if (oStall !== 7'b1111000) $display("FAIL ovf_stall3: got %b want 1111000", oStall); else passed++;
                total++; if (oOverflow !== 1'b0) $display("FAIL ovf_flag3: got %b want 0", oOverflow); else passed++;
            end
            if (c == 4) begin
                total++; if (oOverflow !== 1'b1) $display("FAIL ovf_flag4: got %b want 1", oOverflow); else passed++;
            end
        end
        iWren = '0;
        n = 0;
        while (oBusy === 1'b1 && n < 100) begin
            tick;
            if (oWren === 1'b1) writes++;
            n++;
        end
        total++; if (oBusy !== 1'b0) $display("FAIL ovf_drain: got busy %b want 0", oBusy); else passed++;
        total++; if (writes != 36) $display("FAIL ovf_writes: got %0d want 36", writes); else passed++;
        total++; if (oDropCount !== exp_drop) $display("FAIL ovf_dropcount: got %0d want %0d", oDropCount, exp_drop); else passed++;
`ifdef RESULT_ARB_DROP_COUNT_EN
        total++; if (writes + int'(oDropCount) != 70) $display("FAIL ovf_sum: got %0d want 70", writes + int'(oDropCount)); else passed++;
`endif
        total++; if (oOverflow !== 1'b1 || oStall !== 7'h0) $display("FAIL ovf_sticky: got ovf %b stall %b want 1 0000000", oOverflow, oStall); else passed++;
    endtask

    initial begin
        test_reset;
        test_single;
        test_burst;
        test_reset_mid;
        test_wrap;
        test_fairness;
        test_overflow;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
